// File: rtl/bank_switch_ctrl.sv
// Bank switch controller: accepts SET/PUSH/POP commands and drives a one-cycle
// load strobe to a downstream bank register after a programmable delay.
// PUSH and POP keep a return stack of previously committed banks.
module bank_switch_ctrl #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int DELAY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [WIDTH-1:0]             cmd_bank,
    output logic                         bank_ce,
    output logic [WIDTH-1:0]             bank_new,
    output logic [WIDTH-1:0]             cur_bank,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         err_ovf,
    output logic                         err_unf,
    input  logic                         err_clr
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
    localparam logic [CW-1:0]  CNT_LOAD = CW'((DELAY > 0) ? DELAY - 1 : 0);

    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             cmd_ready_reg;
    logic             bank_ce_reg;
    logic             err_ovf_reg;
    logic             err_unf_reg;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] bank_new_reg;
    logic [WIDTH-1:0] cur_bank_reg;
    logic [SPW-1:0]   sp_reg;
    logic [WIDTH-1:0] stack_mem [DEPTH];

    logic             accept;
    logic             stack_full;
    logic             stack_empty;
    logic             push_ok;
    logic             pop_ok;
    logic             ovf_event;
    logic             unf_event;
    logic             go;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic [WIDTH-1:0] target_next;

    // Command decode: classify the accepted command and pick the new target.
    always_comb begin
        accept      = cmd_valid && cmd_ready_reg;
        stack_full  = (sp_reg == SP_FULL);
        stack_empty = (sp_reg == '0);
        push_ok     = accept && (cmd_op == OP_PUSH) && !stack_full;
        pop_ok      = accept && (cmd_op == OP_POP) && !stack_empty;
        ovf_event   = accept && (cmd_op == OP_PUSH) && stack_full;
        unf_event   = accept && (cmd_op == OP_POP) && stack_empty;
        go          = (accept && (cmd_op == OP_SET)) || push_ok || pop_ok;
        push_idx    = AW'(sp_reg);
        pop_idx     = AW'(sp_reg - 1'b1);
        target_next = (cmd_op == OP_POP) ? stack_mem[pop_idx] : cmd_bank;
    end

    // Return stack storage; popped entries are left in place, sp alone marks validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[push_idx] <= cur_bank_reg;
        end
    end

    // Main FSM: IDLE accepts, WAIT counts the delay, COMMIT pulses the load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cmd_ready_reg <= 1'b1;
            bank_ce_reg   <= 1'b0;
            target_reg    <= '0;
            bank_new_reg  <= '0;
            cur_bank_reg  <= '0;
            sp_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        target_reg    <= target_next;
                        cmd_ready_reg <= 1'b0;
                        if (push_ok) begin
                            sp_reg <= sp_reg + 1'b1;
                        end else if (pop_ok) begin
                            sp_reg <= sp_reg - 1'b1;
                        end
                        if (DELAY == 0) begin
                            state_reg    <= COMMIT;
                            bank_ce_reg  <= 1'b1;
                            bank_new_reg <= target_next;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    // Counts down to zero and stops; the counter never wraps.
                    if (cnt_reg == '0) begin
                        state_reg    <= COMMIT;
                        bank_ce_reg  <= 1'b1;
                        bank_new_reg <= target_reg;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                COMMIT: begin
                    state_reg     <= IDLE;
                    bank_ce_reg   <= 1'b0;
                    cur_bank_reg  <= target_reg;
                    cmd_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    bank_ce_reg   <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Sticky error flags; a new error event takes priority over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            if (ovf_event) begin
                err_ovf_reg <= 1'b1;
            end else if (err_clr) begin
                err_ovf_reg <= 1'b0;
            end
            if (unf_event) begin
                err_unf_reg <= 1'b1;
            end else if (err_clr) begin
                err_unf_reg <= 1'b0;
            end
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign bank_ce   = bank_ce_reg;
    assign bank_new  = bank_new_reg;
    assign cur_bank  = cur_bank_reg;
    assign sp        = sp_reg;
    assign err_ovf   = err_ovf_reg;
    assign err_unf   = err_unf_reg;

endmodule

// File: tb/tb_bank_switch_ctrl.sv
// Bench for bank_switch_ctrl: directed scenarios plus a randomized command
// stream compared against a queue-based model of the bank/return-stack rules.
module tb_bank_switch_ctrl;

    localparam int W = 2;
    localparam int N = 4;
    localparam int D = 1;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] SET  = 2'b01;
    localparam logic [1:0] PUSH = 2'b10;
    localparam logic [1:0] POP  = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_bank = '0;
    logic         bank_ce;
    logic [W-1:0] bank_new;
    logic [W-1:0] cur_bank;
    logic [2:0]   sp;
    logic         err_ovf;
    logic         err_unf;
    logic         err_clr = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    bank_switch_ctrl #(.WIDTH(W), .DEPTH(N), .DELAY(D)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_bank(cmd_bank), .bank_ce(bank_ce), .bank_new(bank_new),
        .cur_bank(cur_bank), .sp(sp), .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Reset asserted and released between clock edges; returns 1 time unit after an edge.
    task automatic apply_reset();
        @(posedge clk); #3;
        rst = 1'b1; cmd_valid = 1'b0; err_clr = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issues one command and observes the following six cycles.
    // ce_lat / rdy_lat count cycles after the accept edge (0 = cycle right after it).
    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] b,
                          output int ok, output int ce_cnt, output int ce_lat,
                          output logic [W-1:0] ce_val, output logic [2:0] sp_after,
                          output int rdy_lat);
        int n;
        ok = 1; ce_cnt = 0; ce_lat = -1; rdy_lat = -1; ce_val = '0; sp_after = '0;
        cmd_valid = 1'b1; cmd_op = op; cmd_bank = b;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) sp_after = sp;
            if (bank_ce) begin
                ce_cnt++;
                if (ce_lat < 0) begin ce_lat = c - 1; ce_val = bank_new; end
            end
            if (cmd_ready && rdy_lat < 0) rdy_lat = c - 1;
            @(posedge clk); #1;
        end
        $display("[TB] txn op=%0d bank=%0d ce_cnt=%0d ce_val=%0d ce_lat=%0d sp=%0d cur=%0d ovf=%0b unf=%0b",
                 op, b, ce_cnt, ce_val, ce_lat, sp_after, cur_bank, err_ovf, err_unf);
    endtask

    task automatic test_reset();
        #2;
        apply_reset();
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %0b expected 1", cmd_ready); end
        tests_run++; if (bank_ce !== 1'b0) begin tests_failed++; $display("FAIL reset_ce: got %0b expected 0", bank_ce); end
        tests_run++; if (bank_new !== 2'd0) begin tests_failed++; $display("FAIL reset_bank_new: got %0d expected 0", bank_new); end
        tests_run++; if (cur_bank !== 2'd0) begin tests_failed++; $display("FAIL reset_cur_bank: got %0d expected 0", cur_bank); end
        tests_run++; if (sp !== 3'd0) begin tests_failed++; $display("FAIL reset_sp: got %0d expected 0", sp); end
        tests_run++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got ovf=%0b unf=%0b expected 0 0", err_ovf, err_unf); end
        // Asynchronous reset hitting COMMIT of a SET 2
        cmd_valid = 1'b1; cmd_op = SET; cmd_bank = 2'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (bank_ce !== 1'b1) begin tests_failed++; $display("FAIL async_pre_ce: got %0b expected 1", bank_ce); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (bank_ce !== 1'b0 || bank_new !== 2'd0) begin tests_failed++; $display("FAIL async_reset_ce: got ce=%0b new=%0d expected 0 0", bank_ce, bank_new); end
        tests_run++; if (cmd_ready !== 1'b1 || cur_bank !== 2'd0) begin tests_failed++; $display("FAIL async_reset_state: got rdy=%0b cur=%0d expected 1 0", cmd_ready, cur_bank); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (bank_ce !== 1'b0 || cur_bank !== 2'd0) begin tests_failed++; $display("FAIL async_after_release: got ce=%0b cur=%0d expected 0 0", bank_ce, cur_bank); end
    endtask

    task automatic test_set();
        int ok, cc, cl, rl; logic [W-1:0] cv; logic [2:0] sa;
        apply_reset();
        do_cmd(SET, 2'd2, ok, cc, cl, cv, sa, rl);
        tests_run++; if (ok != 1) begin tests_failed++; $display("FAIL set_accept: got ready timeout expected accept"); end
        tests_run++; if (cc != 1) begin tests_failed++; $display("FAIL set_ce_count: got %0d expected 1", cc); end
        tests_run++; if (cl != D || cv !== 2'd2) begin tests_failed++; $display("FAIL set_ce: got lat=%0d val=%0d expected lat=%0d val=2", cl, cv, D); end
        tests_run++; if (rl != D + 1) begin tests_failed++; $display("FAIL set_ready_lat: got %0d expected %0d", rl, D + 1); end
        tests_run++; if (cur_bank !== 2'd2 || bank_new !== 2'd2) begin tests_failed++; $display("FAIL set_cur_bank: got cur=%0d new=%0d expected 2 2", cur_bank, bank_new); end
        // Same bank again still commits
        do_cmd(SET, 2'd2, ok, cc, cl, cv, sa, rl);
        tests_run++; if (cc != 1 || cv !== 2'd2) begin tests_failed++; $display("FAIL set_same_bank: got cnt=%0d val=%0d expected 1 2", cc, cv); end
        // NOP: no strobe, ready right away
        do_cmd(NOP, 2'd1, ok, cc, cl, cv, sa, rl);
        tests_run++; if (cc != 0 || rl != 0 || cur_bank !== 2'd2) begin tests_failed++; $display("FAIL nop: got cnt=%0d rdy_lat=%0d cur=%0d expected 0 0 2", cc, rl, cur_bank); end
    endtask

    task automatic test_stack();
        int ok, cc, cl, rl; logic [W-1:0] cv; logic [2:0] sa;
        logic [1:0] ops [4];
        logic [W-1:0] banks [4];
        logic [W-1:0] exp_v [4];
        logic [2:0] exp_sp [4];
        ops = '{PUSH, PUSH, POP, POP};
        banks = '{2'd1, 2'd3, 2'd0, 2'd0};
        exp_v = '{2'd1, 2'd3, 2'd1, 2'd0};
        exp_sp = '{3'd1, 3'd2, 3'd1, 3'd0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_cmd(ops[i], banks[i], ok, cc, cl, cv, sa, rl);
            tests_run++; if (cc != 1 || cv !== exp_v[i]) begin tests_failed++; $display("FAIL stack_ce_%0d: got cnt=%0d val=%0d expected 1 %0d", i, cc, cv, exp_v[i]); end
            tests_run++; if (sa !== exp_sp[i]) begin tests_failed++; $display("FAIL stack_sp_%0d: got %0d expected %0d", i, sa, exp_sp[i]); end
        end
    endtask

    task automatic test_overflow();
        int ok, cc, cl, rl; logic [W-1:0] cv; logic [2:0] sa;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            do_cmd(PUSH, W'($urandom), ok, cc, cl, cv, sa, rl);
            tests_run++; if (cc != 1 || sa !== 3'(i + 1)) begin tests_failed++; $display("FAIL ovf_fill_%0d: got cnt=%0d sp=%0d expected 1 %0d", i, cc, sa, i + 1); end
        end
        do_cmd(PUSH, 2'd2, ok, cc, cl, cv, sa, rl);
        tests_run++; if (cc != 0) begin tests_failed++; $display("FAIL ovf_no_ce: got %0d expected 0", cc); end
        tests_run++; if (err_ovf !== 1'b1 || sp !== 3'd4) begin tests_failed++; $display("FAIL ovf_flag: got ovf=%0b sp=%0d expected 1 4", err_ovf, sp); end
        tests_run++; if (rl != 0) begin tests_failed++; $display("FAIL ovf_ready: got lat=%0d expected 0", rl); end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        tests_run++; if (err_ovf !== 1'b0 || sp !== 3'd4) begin tests_failed++; $display("FAIL ovf_clear: got ovf=%0b sp=%0d expected 0 4", err_ovf, sp); end
    endtask

    task automatic test_underflow();
        int ok, cc, cl, rl; logic [W-1:0] cv; logic [2:0] sa;
        apply_reset();
        do_cmd(POP, 2'd0, ok, cc, cl, cv, sa, rl);
        tests_run++; if (err_unf !== 1'b1 || cc != 0) begin tests_failed++; $display("FAIL unf_flag: got unf=%0b ce_cnt=%0d expected 1 0", err_unf, cc); end
        tests_run++; if (rl != 0 || sa !== 3'd0) begin tests_failed++; $display("FAIL unf_ready: got lat=%0d sp=%0d expected 0 0", rl, sa); end
        cmd_valid = 1'b1; cmd_op = POP; err_clr = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; err_clr = 1'b0;
        tests_run++; if (err_unf !== 1'b1 || bank_ce !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL unf_set_wins: got unf=%0b ce=%0b rdy=%0b expected 1 0 1", err_unf, bank_ce, cmd_ready); end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        tests_run++; if (err_unf !== 1'b0) begin tests_failed++; $display("FAIL unf_clear: got %0b expected 0", err_unf); end
    endtask

    task automatic test_back_to_back();
        int acc2, ce_n;
        logic [W-1:0] vals [4];
        apply_reset();
        acc2 = -1; ce_n = 0;
        cmd_valid = 1'b1; cmd_op = SET; cmd_bank = 2'd1;
        @(posedge clk); #1;
        cmd_bank = 2'd2;
        for (int c = 1; c <= 12; c++) begin
            if (bank_ce) begin
                if (ce_n < 4) vals[ce_n] = bank_new;
                ce_n++;
            end
            if (cmd_ready && cmd_valid && acc2 < 0) acc2 = c;
            @(posedge clk); #1;
            if (acc2 == c) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        $display("[TB] txn back_to_back second_accept=%0d ce_pulses=%0d", acc2, ce_n);
        tests_run++; if (acc2 != D + 2) begin tests_failed++; $display("FAIL b2b_second_accept: got %0d expected %0d", acc2, D + 2); end
        tests_run++; if (ce_n != 2) begin tests_failed++; $display("FAIL b2b_ce_count: got %0d expected 2", ce_n); end
        else begin
            tests_run++; if (vals[0] !== 2'd1 || vals[1] !== 2'd2) begin tests_failed++; $display("FAIL b2b_ce_values: got %0d,%0d expected 1,2", vals[0], vals[1]); end
        end
        tests_run++; if (cur_bank !== 2'd2) begin tests_failed++; $display("FAIL b2b_cur_bank: got %0d expected 2", cur_bank); end
    endtask

    task automatic test_reset_abort();
        int ok, cc, cl, rl, ce_n; logic [W-1:0] cv; logic [2:0] sa;
        apply_reset();
        do_cmd(PUSH, 2'd1, ok, cc, cl, cv, sa, rl);
        tests_run++; if (sp !== 3'd1 || cur_bank !== 2'd1) begin tests_failed++; $display("FAIL abort_setup: got sp=%0d cur=%0d expected 1 1", sp, cur_bank); end
        cmd_valid = 1'b1; cmd_op = SET; cmd_bank = 2'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        ce_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bank_ce) ce_n++;
        end
        $display("[TB] txn reset_abort ce_pulses=%0d cur=%0d sp=%0d", ce_n, cur_bank, sp);
        tests_run++; if (ce_n != 0) begin tests_failed++; $display("FAIL abort_no_ce: got %0d expected 0", ce_n); end
        tests_run++; if (cur_bank !== 2'd0 || sp !== 3'd0 || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_state: got cur=%0d sp=%0d rdy=%0b expected 0 0 1", cur_bank, sp, cmd_ready); end
    endtask

    task automatic test_random();
        int ok, cc, cl, rl; logic [W-1:0] cv; logic [2:0] sa;
        logic [W-1:0] m_stk [$];
        logic [W-1:0] m_cur, exp_val, b;
        logic m_ovf, m_unf, exp_ce;
        logic [1:0] op;
        apply_reset();
        m_cur = '0; m_ovf = 1'b0; m_unf = 1'b0;
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            b = W'($urandom);
            exp_ce = 1'b0; exp_val = '0;
            case (op)
                SET: begin exp_ce = 1'b1; exp_val = b; end
                PUSH: if (m_stk.size() < N) begin m_stk.push_back(m_cur); exp_ce = 1'b1; exp_val = b; end
                      else m_ovf = 1'b1;
                POP: if (m_stk.size() > 0) begin exp_val = m_stk.pop_back(); exp_ce = 1'b1; end
                     else m_unf = 1'b1;
                default: ;
            endcase
            if (exp_ce) m_cur = exp_val;
            do_cmd(op, b, ok, cc, cl, cv, sa, rl);
            tests_run++; if (cc != int'(exp_ce)) begin tests_failed++; $display("FAIL rnd_ce_count_%0d: got %0d expected %0d", t, cc, exp_ce); end
            if (exp_ce) begin
                tests_run++; if (cv !== exp_val || cl != D) begin tests_failed++; $display("FAIL rnd_ce_val_%0d: got val=%0d lat=%0d expected %0d %0d", t, cv, cl, exp_val, D); end
            end
            tests_run++; if (rl != (exp_ce ? D + 1 : 0)) begin tests_failed++; $display("FAIL rnd_ready_%0d: got %0d expected %0d", t, rl, exp_ce ? D + 1 : 0); end
            tests_run++; if (sa !== 3'(m_stk.size()) || cur_bank !== m_cur) begin tests_failed++; $display("FAIL rnd_state_%0d: got sp=%0d cur=%0d expected %0d %0d", t, sa, cur_bank, m_stk.size(), m_cur); end
            tests_run++; if (err_ovf !== m_ovf || err_unf !== m_unf) begin tests_failed++; $display("FAIL rnd_err_%0d: got ovf=%0b unf=%0b expected %0b %0b", t, err_ovf, err_unf, m_ovf, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_stack();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bank_switch_ctrl.md
BANK_SWITCH_CTRL -- requirements
Module: bank_switch_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, meaning the bank number width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of return-stack entries (>=1).
REQ-003 The block SHALL have parameter DELAY, default 1, meaning the extra cycles between command acceptance and commit (>=0).
REQ-004 The block SHALL have port clk  input  1  clock, rising-edge active.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port cmd_valid  input  1  command present.
REQ-007 The block SHALL have port cmd_ready  output  1  command can be accepted.
REQ-008 The block SHALL have port cmd_op  input  2  opcode: 00 NOP, 01 SET, 10 PUSH, 11 POP.
REQ-009 The block SHALL have port cmd_bank  input  WIDTH  target bank for SET/PUSH.
REQ-010 The block SHALL have port bank_ce  output  1  one-cycle load strobe to the downstream bank register.
REQ-011 The block SHALL have port bank_new  output  WIDTH  bank value to load.
REQ-012 The block SHALL have port cur_bank  output  WIDTH  mirror of the committed bank.
REQ-013 The block SHALL have port sp  output  $clog2(DEPTH+1)  stack occupancy.
REQ-014 The block SHALL have ports err_ovf / err_unf  output  1 each  sticky overflow / underflow flags.
REQ-015 The block SHALL have port err_clr  input  1  clears both sticky flags.

Function
REQ-016 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-017 FSM states SHALL be IDLE, WAIT and COMMIT; cmd_ready SHALL be 1 only in IDLE.
REQ-018 NOP SHALL be accepted with no state change, and the FSM SHALL stay in IDLE.
REQ-019 SET SHALL latch cmd_bank as the target.
REQ-020 PUSH with sp<DEPTH SHALL write cur_bank to stack[sp], increment sp at the accept edge, and latch cmd_bank as the target.
REQ-021 POP with sp>0 SHALL latch stack[sp-1] as the target and decrement sp at the accept edge.
REQ-022 PUSH with sp==DEPTH SHALL set err_ovf, be consumed without effect, and leave the FSM in IDLE.
REQ-023 POP with sp==0 SHALL set err_unf, be consumed without effect, and leave the FSM in IDLE.
REQ-024 After a valid SET/PUSH/POP, the FSM SHALL enter WAIT for DELAY cycles (skip WAIT if DELAY==0), then COMMIT for exactly 1 cycle, then IDLE.
REQ-025 bank_ce SHALL be 1 only in COMMIT, with bank_new equal to the target; bank_new SHALL hold the last target otherwise.
REQ-026 cur_bank SHALL update to the target on the clock edge that ends COMMIT.
REQ-027 Latency: a command accepted at edge k SHALL produce bank_ce high in the cycle after edge k+DELAY; cmd_ready SHALL return to 1 after edge k+DELAY+1.
REQ-028 SET to a bank equal to cur_bank SHALL still pass through WAIT and COMMIT and pulse bank_ce.
REQ-029 If err_clr coincides with a new error event, the set SHALL win; otherwise err_clr SHALL clear both flags at the next edge.
REQ-030 Stack entries SHALL not be cleared on pop; only sp SHALL define valid content.
REQ-031 The WAIT counter SHALL be sized $clog2(DELAY+1) bits minimum and SHALL not wrap.

Reset
REQ-032 On rst=1, regardless of clk, the block SHALL force state IDLE, cmd_ready=1 once rst is deasserted, bank_ce=0, bank_new=0, cur_bank=0, sp=0, err_ovf=0, err_unf=0.
REQ-033 rst asserted in WAIT or COMMIT SHALL abort the pending switch with no bank_ce pulse after reset release.

Verification
REQ-034 Reset, SET 2 with DELAY=1 -> bank_ce=1 for exactly one cycle, 2 cycles after the accept edge, with bank_new=2; cur_bank=2 afterwards.
REQ-035 PUSH 1, PUSH 3, POP, POP from cur_bank=0 -> bank_ce values 1,3,1,0 in order; sp sequence 1,2,1,0.
REQ-036 DEPTH=4, five PUSHes -> fifth sets err_ovf=1 with no bank_ce and sp=4; err_clr -> err_ovf=0.
REQ-037 POP at sp=0 -> err_unf=1, no bank_ce, cmd_ready stays 1; err_clr with another empty POP in the same cycle -> err_unf stays 1.
REQ-038 cmd_valid held high with back-to-back SETs 1,2 -> second accepted only after the first COMMIT; exactly two bank_ce pulses.
REQ-039 rst pulse during WAIT of SET 3 -> cur_bank=0, no bank_ce after release, sp=0.
